// File: rtl/ascon_round_sequencer_if.sv
// Bundle between the Ascon round sequencer and its controller / unrolled datapath.
// Handshake: start is taken only while busy=0. busy acts as valid for rnd/rc and adv as ready, so a step advances on busy&&adv. done marks completion and err marks a rejected start; each is a one-cycle pulse.
interface ascon_round_sequencer_if #(
    parameter int UNROLL = 1
);
    logic                  start;
    logic [1:0]            mode;
    logic                  adv;
    logic                  abort;
    logic                  busy;
    logic                  first;
    logic                  last;
    logic                  done;
    logic                  err;
    logic [UNROLL*4-1:0]   rnd;
    logic [UNROLL*8-1:0]   rc;
    logic                  dbg_run;
    logic [1:0]            dbg_mode;

    modport master (
        output start, mode, adv, abort,
        input  busy, first, last, done, err, rnd, rc, dbg_run, dbg_mode
    );

    modport slave (
        input  start, mode, adv, abort,
        output busy, first, last, done, err, rnd, rc, dbg_run, dbg_mode
    );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Schedules Ascon permutation rounds, issuing UNROLL round indices and round constants per step.
// The sequence always ends at absolute round NR_A-1, so shorter modes simply start later.
module ascon_round_sequencer #(
    parameter int UNROLL = 1,
    parameter int NR_A   = 12,
    parameter int NR_B   = 8,
    parameter int NR_C   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ascon_round_sequencer_if.slave   bus
);

    if (NR_A > 15 || UNROLL < 1) begin : g_bad_params
        $error("ascon_round_sequencer: NR_A must be <= 15 and UNROLL >= 1");
    end

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] NR_A4 = 4'(NR_A);
    localparam logic [3:0] UN4   = 4'(UNROLL);

    state_t     state_q, state_d;
    logic [3:0] base_q, base_d;
    logic [1:0] mode_q, mode_d;
    logic       first_q, first_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    int         n_sel;
    logic       illegal_w;
    logic [3:0] start_idx_w;
    logic       last_w;

    always_comb begin
        case (bus.mode)
            2'b00:   n_sel = NR_A;
            2'b01:   n_sel = NR_B;
            2'b10:   n_sel = NR_C;
            default: n_sel = NR_A;
        endcase
        illegal_w   = (bus.mode == 2'b11) || ((n_sel % UNROLL) != 0);
        start_idx_w = 4'(NR_A - n_sel);
    end

    assign last_w = ((base_q + UN4) == NR_A4);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        mode_d  = mode_q;
        first_d = first_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (illegal_w) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        base_d  = start_idx_w;
                        mode_d  = bus.mode;
                        first_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort takes priority over a simultaneous adv and suppresses done
                if (bus.abort) begin
                    state_d = IDLE;
                    first_d = 1'b0;
                end else if (bus.adv) begin
                    first_d = 1'b0;
                    if (last_w) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        base_d = base_q + UN4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= 4'd0;
            mode_q  <= 2'b00;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    logic [UNROLL*4-1:0] rnd_w;
    logic [UNROLL*8-1:0] rc_w;
    logic [3:0]          slot_r;

    // rc_k = ((15 - r) << 4) | r, and 15 - r is the bitwise inverse of a 4-bit r
    always_comb begin
        rnd_w  = '0;
        rc_w   = '0;
        slot_r = 4'd0;
        for (int k = 0; k < UNROLL; k++) begin
            slot_r = base_q + 4'(k);
            if (state_q == RUN) begin
                rnd_w[4*k +: 4] = slot_r;
                rc_w[8*k +: 8]  = {~slot_r, slot_r};
            end
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.first    = (state_q == RUN) && first_q;
    assign bus.last     = (state_q == RUN) && last_w;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rnd      = rnd_w;
    assign bus.rc       = rc_w;
    assign bus.dbg_run  = (state_q == RUN);
    assign bus.dbg_mode = mode_q;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: three instances (UNROLL 1, 2, 4) share one stimulus path chosen by sel.
// A step-level reference model predicts every output each cycle; table vectors and directed sequences add fixed expectations.
module tb_ascon_round_sequencer;

    localparam int NR_A = 12;
    localparam int NR_B = 8;
    localparam int NR_C = 6;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         sel;
    logic       t_start;
    logic [1:0] t_mode;
    logic       t_adv;
    logic       t_abort;

    ascon_round_sequencer_if #(.UNROLL(1)) if0 ();
    ascon_round_sequencer_if #(.UNROLL(2)) if1 ();
    ascon_round_sequencer_if #(.UNROLL(4)) if2 ();

    ascon_round_sequencer #(.UNROLL(1), .NR_A(NR_A), .NR_B(NR_B), .NR_C(NR_C))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ascon_round_sequencer #(.UNROLL(2), .NR_A(NR_A), .NR_B(NR_B), .NR_C(NR_C))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ascon_round_sequencer #(.UNROLL(4), .NR_A(NR_A), .NR_B(NR_B), .NR_C(NR_C))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = (sel == 0) && t_start;
    assign if1.start = (sel == 1) && t_start;
    assign if2.start = (sel == 2) && t_start;
    assign if0.adv   = (sel == 0) && t_adv;
    assign if1.adv   = (sel == 1) && t_adv;
    assign if2.adv   = (sel == 2) && t_adv;
    assign if0.abort = (sel == 0) && t_abort;
    assign if1.abort = (sel == 1) && t_abort;
    assign if2.abort = (sel == 2) && t_abort;
    assign if0.mode  = t_mode;
    assign if1.mode  = t_mode;
    assign if2.mode  = t_mode;

    logic        o_busy, o_first, o_last, o_done, o_err;
    logic [23:0] o_rnd;
    logic [47:0] o_rc;

    always_comb begin
        case (sel)
            0: begin
                o_busy = if0.busy; o_first = if0.first; o_last = if0.last;
                o_done = if0.done; o_err = if0.err;
                o_rnd = 24'(if0.rnd); o_rc = 48'(if0.rc);
            end
            1: begin
                o_busy = if1.busy; o_first = if1.first; o_last = if1.last;
                o_done = if1.done; o_err = if1.err;
                o_rnd = 24'(if1.rnd); o_rc = 48'(if1.rc);
            end
            default: begin
                o_busy = if2.busy; o_first = if2.first; o_last = if2.last;
                o_done = if2.done; o_err = if2.err;
                o_rnd = 24'(if2.rnd); o_rc = 48'(if2.rc);
            end
        endcase
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %h expected %h", name, sel, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is described by: active?, start round S, step number j, and pulse flags.
    int   unroll_of [3] = '{1, 2, 4};
    bit   m_active [3];
    int   m_s      [3];
    int   m_j      [3];
    bit   m_done   [3];
    bit   m_err    [3];

    function automatic int rounds_for(input logic [1:0] m);
        case (m)
            2'b00:   return NR_A;
            2'b01:   return NR_B;
            2'b10:   return NR_C;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 0; m_s[i] = 0; m_j[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            bit s, a, ab;
            int u, n, next_first_round;
            s  = (sel == i) && t_start;
            a  = (sel == i) && t_adv;
            ab = (sel == i) && t_abort;
            u  = unroll_of[i];
            m_done[i] = 0;
            m_err[i]  = 0;
            if (!m_active[i]) begin
                if (s && !ab) begin
                    n = rounds_for(t_mode);
                    if (n < 0 || (n % u) != 0) begin
                        m_err[i] = 1;
                    end else begin
                        m_active[i] = 1;
                        m_s[i] = NR_A - n;
                        m_j[i] = 0;
                    end
                end
            end else if (ab) begin
                m_active[i] = 0;
            end else if (a) begin
                next_first_round = m_s[i] + (m_j[i] + 1) * u;
                if (next_first_round >= NR_A) begin
                    m_active[i] = 0;
                    m_done[i] = 1;
                end else begin
                    m_j[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [23:0] e_rnd;
        logic [47:0] e_rc;
        int u, r, first_r;
        bit e_first, e_last;
        u = unroll_of[sel];
        e_rnd = '0;
        e_rc  = '0;
        e_first = 0;
        e_last  = 0;
        if (m_active[sel]) begin
            first_r = m_s[sel] + m_j[sel] * u;
            e_first = (m_j[sel] == 0);
            e_last  = (first_r + u == NR_A);
            for (int k = 0; k < u; k++) begin
                r = first_r + k;
                e_rnd[4*k +: 4] = 4'(r);
                e_rc[8*k +: 8]  = {4'(15 - r), 4'(r)};
            end
        end
        check_val("busy",  48'(o_busy),  48'(m_active[sel]));
        check_val("first", 48'(o_first), 48'(e_first));
        check_val("last",  48'(o_last),  48'(e_last));
        check_val("done",  48'(o_done),  48'(m_done[sel]));
        check_val("err",   48'(o_err),   48'(m_err[sel]));
        check_val("rnd",   48'(o_rnd),   48'(e_rnd));
        check_val("rc",    o_rc,         e_rc);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive inputs, let one posedge pass, then check at the next negedge.
    task automatic step(input logic s, input logic [1:0] m, input logic a, input logic ab);
        t_start = s; t_mode = m; t_adv = a; t_abort = ab;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while (o_busy && g < budget) begin
            step(1'b0, 2'b00, 1'b1, 1'b0);
            g++;
        end
        check_val("drain_timeout", 48'(o_busy), 48'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          sel;
        logic [1:0]  mode;
        logic        exp_err;
        int          exp_steps;
        logic [23:0] exp_rnd;
        logic [47:0] exp_rc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 2'b00, 1'b0, 12, 24'h0,    48'hF0};
        vecs[1] = '{1, 2'b01, 1'b0, 4,  24'h54,   48'hA5B4};
        vecs[2] = '{2, 2'b10, 1'b1, 0,  24'h0,    48'h0};
        vecs[3] = '{2, 2'b00, 1'b0, 3,  24'h3210, 48'hC3D2E1F0};
        vecs[4] = '{0, 2'b11, 1'b1, 0,  24'h0,    48'h0};
        vecs[5] = '{1, 2'b10, 1'b0, 3,  24'h76,   48'h8796};
        vecs[6] = '{2, 2'b01, 1'b0, 2,  24'h7654, 48'h8796A5B4};
        vecs[7] = '{0, 2'b10, 1'b0, 6,  24'h6,    48'h96};

        sel = 0; t_start = 0; t_mode = 0; t_adv = 0; t_abort = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // table vectors: start, then run with adv high and count busy steps
        foreach (vecs[v]) begin
            int cnt, g;
            sel = vecs[v].sel;
            step(1'b0, 2'b00, 1'b0, 1'b1);
            step(1'b1, vecs[v].mode, 1'b1, 1'b0);
            check_val("vec_err", 48'(o_err), 48'(vecs[v].exp_err));
            if (!vecs[v].exp_err) begin
                check_val("vec_rnd0", 48'(o_rnd), 48'(vecs[v].exp_rnd));
                check_val("vec_rc0",  o_rc,       vecs[v].exp_rc);
            end
            cnt = 0; g = 0;
            while (o_busy && g < 40) begin
                cnt++;
                step(1'b0, 2'b00, 1'b1, 1'b0);
                g++;
            end
            check_val("vec_steps", 48'(cnt), 48'(vecs[v].exp_steps));
            check_val("vec_done",  48'(o_done), 48'(!vecs[v].exp_err));
            step(1'b0, 2'b00, 1'b0, 1'b0);
        end

        // stall at rnd=3 for 5 cycles
        sel = 0;
        step(1'b1, 2'b00, 1'b1, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b1, 1'b0);
        repeat (5) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            check_val("stall_rnd",  48'(o_rnd),  48'(3));
            check_val("stall_rc",   o_rc,        48'hC3);
            check_val("stall_busy", 48'(o_busy), 48'(1));
        end
        drain(20);
        check_val("stall_done", 48'(o_done), 48'(1));

        // start during RUN is ignored; abort at rnd=7 ends with no done
        step(1'b1, 2'b00, 1'b1, 1'b0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        repeat (6) step(1'b0, 2'b00, 1'b1, 1'b0);
        check_val("pre_abort_rnd", 48'(o_rnd), 48'(7));
        step(1'b0, 2'b00, 1'b1, 1'b1);
        check_val("abort_busy", 48'(o_busy), 48'(0));
        check_val("abort_done", 48'(o_done), 48'(0));
        repeat (3) step(1'b0, 2'b00, 1'b1, 1'b0);

        // start and abort together in IDLE
        step(1'b1, 2'b00, 1'b1, 1'b1);
        check_val("sa_busy", 48'(o_busy), 48'(0));
        check_val("sa_err",  48'(o_err),  48'(0));

        // asynchronous reset mid-sequence at rnd=5
        step(1'b1, 2'b00, 1'b1, 1'b0);
        repeat (5) step(1'b0, 2'b00, 1'b1, 1'b0);
        check_val("pre_rst_rnd", 48'(o_rnd), 48'(5));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b01, 1'b0, 1'b0);
        check_val("post_rst_rnd", 48'(o_rnd), 48'(4));
        check_val("post_rst_first", 48'(o_first), 48'(1));
        drain(20);

        // randomized traffic against the model on each instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int c = 0; c < 600; c++) begin
                step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0);
            end
            step(1'b0, 2'b00, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
